// File: rtl/f1_pkg.sv
// Shared types and constants for the reaction timer: FSM state encoding,
// the 14-bit millisecond type and the default timeout limit.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE
  } state_t;

  typedef logic [13:0] ms_t;

  localparam int unsigned MAX_MS_DEFAULT = 9999;
  localparam ms_t         BEST_RESET     = 14'h3FFF;

endpackage

// File: rtl/key_debounce.sv
// Driver key conditioning: 2-flop synchroniser, tick-based debouncer and
// a one-clk press pulse on the debounced released-to-pressed edge.
module key_debounce
  import f1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  logic [1:0]    sync_q, sync_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d = {sync_q[0], key_n};
    db_d   = db_q;
    cnt_d  = cnt_q;
    // Any return to the accepted level restarts the stability count.
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (tick_ms) begin
      if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
        db_d  = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = db_q & ~db_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/reaction_timer.sv
// Driver reaction timer: measures ms from lights_out to a debounced key
// press, flags jump starts and timeouts. Define BEST_TIME_EN for best_ms.
module reaction_timer
  import f1_pkg::*;
#(
  parameter int unsigned MAX_MS      = MAX_MS_DEFAULT,
  parameter int unsigned DEBOUNCE_MS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_ms,
  input  logic        arm,
  input  logic        lights_out,
  input  logic        key_n,
  output logic [13:0] react_ms,
  output logic        result_valid,
  output logic        jump_start,
  output logic        timed_out,
  output logic        busy,
  output logic [13:0] best_ms
);

  logic   press;
  state_t state_q, state_d;
  ms_t    count_q, count_d;
  ms_t    react_q, react_d;
  logic   valid_q, valid_d;
  logic   jump_q, jump_d;
  logic   tmo_q, tmo_d;
  logic   busy_q, busy_d;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_ms (tick_ms),
    .key_n   (key_n),
    .press   (press)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    react_d = react_q;
    jump_d  = jump_q;
    tmo_d   = tmo_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = ARMED;
          react_d = '0;
          jump_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      ARMED: begin
        // Press wins over a coincident lights_out: that is a jump start.
        if (press) begin
          state_d = DONE;
          jump_d  = 1'b1;
          react_d = '0;
          valid_d = 1'b1;
        end else if (lights_out) begin
          state_d = TIMING;
          count_d = '0;
        end
      end
      TIMING: begin
        if (tick_ms) count_d = count_q + ms_t'(1);
        if (press) begin
          state_d = DONE;
          react_d = count_d;
          valid_d = 1'b1;
        end else if (count_d >= ms_t'(MAX_MS)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          react_d = ms_t'(MAX_MS);
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ARMED) || (state_d == TIMING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      react_q <= '0;
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      react_q <= react_d;
      valid_q <= valid_d;
      jump_q  <= jump_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BEST_TIME_EN
  ms_t best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (valid_d && !jump_d && !tmo_d && (react_d < best_q)) best_d = react_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) best_q <= BEST_RESET;
    else        best_q <= best_d;
  end

  assign best_ms = best_q;
`else
  assign best_ms = '0;
`endif

  assign react_ms     = react_q;
  assign result_valid = valid_q;
  assign jump_start   = jump_q;
  assign timed_out    = tmo_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed self-checking bench for reaction_timer (table rows plus
// hand-written multi-cycle sequences).
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_ms = 1'b0;
  logic        arm = 1'b0;
  logic        lights_out = 1'b0;
  logic        key_n = 1'b1;
  logic [13:0] react_ms;
  logic        result_valid;
  logic        jump_start;
  logic        timed_out;
  logic        busy;
  logic [13:0] best_ms;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;

  reaction_timer #(.MAX_MS(9999), .DEBOUNCE_MS(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_ms      (tick_ms),
    .arm          (arm),
    .lights_out   (lights_out),
    .key_n        (key_n),
    .react_ms     (react_ms),
    .result_valid (result_valid),
    .jump_start   (jump_start),
    .timed_out    (timed_out),
    .busy         (busy),
    .best_ms      (best_ms)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (result_valid === 1'b1) nvalid <= nvalid + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time-limit expiry, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit arm;
    bit lo;
    bit key_n;
    int ticks;
    bit busy;
    bit jump;
    bit tmo;
    int react;
    int nv;
  } vec_t;

  vec_t tbl [22];

`ifdef BEST_TIME_EN
  localparam bit BEST_ON = 1'b1;
`else
  localparam bit BEST_ON = 1'b0;
`endif

  function automatic int exp_best(input int v);
    return BEST_ON ? v : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick_ms = 1'b0;
    step(); step(); step();
    tick_ms = 1'b1;
    step();
    tick_ms = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) tick_once();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_lo();
    lights_out = 1'b1; step(); lights_out = 1'b0;
  endtask

  task automatic timed_run(input int n);
    pulse_arm();
    pulse_lo();
    do_ticks(n - 5);
    key_n = 1'b0;
    do_ticks(5);
    step(); step();
    check($sformatf("run%0d react", n), react_ms, n);
    key_n = 1'b1;
    do_ticks(5);
  endtask

  initial begin
    int nv0;
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0,  0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0,  0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 0,  0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0, 0,  1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0,  0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 7, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 12, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 12, 0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 14, 1};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 14, 0};

    // Reset state
    step(); step();
    check("rst busy", busy, 0);
    check("rst react", react_ms, 0);
    check("rst valid", result_valid, 0);
    check("rst best", best_ms, BEST_ON ? 32'h3FFF : 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 22; i++) begin
      nv0 = nvalid;
      arm = tbl[i].arm; lights_out = tbl[i].lo; key_n = tbl[i].key_n;
      step();
      arm = 1'b0; lights_out = 1'b0;
      do_ticks(tbl[i].ticks);
      step(); step();
      check($sformatf("row%0d busy", i), busy, tbl[i].busy);
      check($sformatf("row%0d jump", i), jump_start, tbl[i].jump);
      check($sformatf("row%0d tmo", i), timed_out, tbl[i].tmo);
      check($sformatf("row%0d react", i), react_ms, tbl[i].react);
      check($sformatf("row%0d nvalid", i), nvalid - nv0, tbl[i].nv);
    end
    check("table best", best_ms, exp_best(12));

    // 250 ticks after lights_out, then debounce adds 5; valid exactly one clk
    pulse_arm();
    pulse_lo();
    do_ticks(250);
    key_n = 1'b0;
    do_ticks(4);
    step(); step(); step();
    tick_ms = 1'b1; step(); tick_ms = 1'b0;
    check("r250 valid early", result_valid, 0);
    check("r250 busy early", busy, 1);
    step();
    check("r250 valid", result_valid, 1);
    check("r250 react", react_ms, 255);
    check("r250 busy", busy, 0);
    step();
    check("r250 valid drop", result_valid, 0);
    key_n = 1'b1;
    do_ticks(5);
    check("r250 hold", react_ms, 255);

    // Timeout at MAX_MS
    pulse_arm();
    check("tmo cleared", timed_out, 0);
    pulse_lo();
    do_ticks(9998);
    check("tmo pre busy", busy, 1);
    check("tmo pre flag", timed_out, 0);
    tick_once();
    check("tmo valid", result_valid, 1);
    check("tmo flag", timed_out, 1);
    check("tmo react", react_ms, 9999);
    check("tmo busy", busy, 0);
    check("tmo jump", jump_start, 0);
    step();
    check("tmo valid drop", result_valid, 0);

    // Press and lights_out in the same ARMED cycle
    pulse_arm();
    key_n = 1'b0;
    do_ticks(4);
    step(); step(); step();
    tick_ms = 1'b1; step(); tick_ms = 1'b0;
    lights_out = 1'b1; step(); lights_out = 1'b0;
    check("same jump", jump_start, 1);
    check("same busy", busy, 0);
    check("same valid", result_valid, 1);
    check("same react", react_ms, 0);
    key_n = 1'b1;
    do_ticks(5);

    // Reset mid-measurement
    pulse_arm();
    pulse_lo();
    do_ticks(10);
    nv0 = nvalid;
    rst_n = 1'b0;
    #2;
    check("mid rst busy", busy, 0);
    check("mid rst react", react_ms, 0);
    check("mid rst jump", jump_start, 0);
    check("mid rst tmo", timed_out, 0);
    check("mid rst valid", result_valid, 0);
    check("mid rst best", best_ms, BEST_ON ? 32'h3FFF : 0);
    step(); step();
    rst_n = 1'b1;
    do_ticks(3);
    step();
    check("post rst busy", busy, 0);
    check("post rst nvalid", nvalid - nv0, 0);

    // Best time tracking
    timed_run(300);
    check("best 300", best_ms, exp_best(300));
    timed_run(200);
    check("best 200", best_ms, exp_best(200));
    timed_run(400);
    check("best 400", best_ms, exp_best(200));
    pulse_arm();
    key_n = 1'b0;
    do_ticks(5);
    step(); step();
    check("best jump flag", jump_start, 1);
    check("best after jump", best_ms, exp_best(200));
    key_n = 1'b1;
    do_ticks(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter MAX_MS, default 9999: timeout limit in ms; react_ms saturates here.
REQ-002 Parameter DEBOUNCE_MS, default 5: ms the synchronised key must stay stable before a change is accepted.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tick_ms  input  1  one-clk-wide 1 kHz enable pulse.
REQ-006 arm  input  1  one-clk pulse from the light-sequence controller when the light sequence starts.
REQ-007 lights_out  input  1  one-clk pulse from the light-sequence controller when all lights extinguish.
REQ-008 key_n  input  1  raw driver button, active-low, asynchronous to clk.
REQ-009 react_ms  output  14  measured reaction time in ms, binary, held until the next arm.
REQ-010 result_valid  output  1  one-clk pulse on entry to DONE.
REQ-011 jump_start  output  1  level: press before lights_out.
REQ-012 timed_out  output  1  level: no press within MAX_MS.
REQ-013 busy  output  1  high in ARMED and TIMING.
REQ-014 best_ms  output  14  lowest valid react_ms since reset.

Function
REQ-015 key_n SHALL pass through a 2-flop synchroniser, then the debouncer; press event = one-clk pulse on the debounced released-to-pressed transition.
REQ-016 The debouncer SHALL accept a new level only after it is unchanged for DEBOUNCE_MS consecutive tick_ms pulses.
REQ-017 FSM states SHALL be IDLE, ARMED, TIMING and DONE.
REQ-018 In IDLE, arm SHALL move the FSM to ARMED; press and lights_out are ignored.
REQ-019 In ARMED, a press event SHALL move the FSM to DONE with jump_start=1 and react_ms=0.
REQ-020 In ARMED, lights_out without a press SHALL clear the counter and move the FSM to TIMING.
REQ-021 A press and lights_out in the same ARMED cycle SHALL count as a jump start.
REQ-022 In TIMING, each tick_ms SHALL increment the counter.
REQ-023 A press in TIMING SHALL go to DONE with react_ms = counter value including any tick_ms in that same cycle.
REQ-024 If the counter reaches MAX_MS in TIMING, the FSM SHALL go to DONE with timed_out=1 and react_ms=MAX_MS.
REQ-025 In DONE, outputs SHALL hold; arm SHALL clear jump_start, timed_out and react_ms and enter ARMED.
REQ-026 arm in ARMED or TIMING SHALL be ignored.
REQ-027 result_valid SHALL assert exactly one clk after the deciding event and last one clk.
REQ-028 A key held across arm SHALL not generate a press until it has been released and pressed again.

Reset
REQ-029 rst_n low SHALL force IDLE, counter 0, react_ms 0, result_valid 0, jump_start 0, timed_out 0, busy 0.
REQ-030 rst_n low SHALL force best_ms to 14'h3FFF and set the debounced key to released.
REQ-031 Reset mid-measurement SHALL discard the measurement with no result_valid pulse.

Configuration
REQ-032 With BEST_TIME_EN defined, best_ms SHALL update on each valid result (not jump_start, not timed_out) whose react_ms is below best_ms.
REQ-033 Without BEST_TIME_EN, best_ms SHALL be constant 0 and no best-time register SHALL be synthesised.

Structure
REQ-034 Package f1_pkg SHALL hold the FSM state enum, the 14-bit ms type and the MAX_MS default constant.
REQ-035 Synchroniser plus debounce logic SHALL be sub-module key_debounce; the FSM and counter stay in reaction_timer.

Verification
REQ-036 Scenario: arm, lights_out, press 250 ticks later -> react_ms=250 + DEBOUNCE_MS, result_valid one clk, busy 0.
REQ-037 Scenario: arm, then press before lights_out -> jump_start=1, react_ms=0, and a following lights_out is ignored.
REQ-038 Scenario: arm, lights_out, no press -> after 9999 ticks timed_out=1, react_ms=9999.
REQ-039 Scenario: 2-tick glitches on key_n with DEBOUNCE_MS=5 -> no press event; a 6-tick low -> one press event.
REQ-040 Scenario: rst_n low during TIMING -> IDLE, all outputs zero, no result_valid pulse.
REQ-041 Scenario: with BEST_TIME_EN, valid results 300 then 200 then 400 -> best_ms=200; without the macro best_ms=0.
